// File: rtl/apa102_multi_out.sv
// apa102_multi_out: multi-channel APA102 serialiser.
// One shared clock line drives CHANNELS strips in lockstep, with one data line per strip.
// Pixels arrive over a valid/ready handshake. Every page is sent as a start frame,
// then the LED slots, then an end frame.
// Optional feature macro: APA102_PER_PIXEL_BRIGHTNESS_EN. When it is defined, each
// pixel is 29 bits wide and carries its own 5-bit brightness in bits [28:24].

module apa102_lane #(
    parameter int PW = 24
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_load,
    input  logic [PW-1:0] i_pix,
    input  logic [4:0]    i_bri,
    input  logic [1:0]    i_sel,
    input  logic [4:0]    i_idx,
    output logic          o_bit
);
    localparam logic [1:0] SEL_ZERO = 2'd0;
    localparam logic [1:0] SEL_ONE  = 2'd1;
    localparam logic [1:0] SEL_HDR  = 2'd2;

    logic [PW-1:0] r_pix;
    logic [7:0]    w_hdr;
    logic [4:0]    w_didx;
    logic [2:0]    w_hidx;

`ifdef APA102_PER_PIXEL_BRIGHTNESS_EN
    assign w_hdr = {3'b111, r_pix[28:24]};
`else
    assign w_hdr = {3'b111, i_bri};
`endif
    assign w_didx = 5'd23 - i_idx;
    assign w_hidx = 3'd7 - i_idx[2:0];

    // Hold the accepted pixel so repeated slots resend it without a new handshake
    always_ff @(posedge clk) begin
        if (rst)
            r_pix <= '0;
        else if (i_load)
            r_pix <= i_pix;
    end

    // Pick the bit for the current segment, sending header and colour MSB first
    always_comb begin
        o_bit = 1'b0;
        case (i_sel)
            SEL_ZERO: o_bit = 1'b0;
            SEL_ONE:  o_bit = 1'b1;
            SEL_HDR:  o_bit = w_hdr[w_hidx];
            default:  o_bit = r_pix[w_didx];
        endcase
    end
endmodule

module apa102_multi_out #(
    parameter int CHANNELS    = 4,
    parameter int COUNT_WIDTH = 16,
    parameter int DIV_WIDTH   = 8,
`ifdef APA102_PER_PIXEL_BRIGHTNESS_EN
    localparam int PW = 29
`else
    localparam int PW = 24
`endif
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start_toggle,
    input  logic [COUNT_WIDTH-1:0] led_count,
    input  logic [1:0]             repeat_count,
    input  logic [7:0]             page_count,
    input  logic [DIV_WIDTH-1:0]   clock_divisor,
    input  logic [4:0]             global_brightness,
    input  logic [CHANNELS*PW-1:0] pixel_data,
    input  logic                   pixel_valid,
    output logic                   pixel_ready,
    output logic                   clock_out,
    output logic [CHANNELS-1:0]    data_out,
    output logic                   busy,
    output logic                   underrun
);
    localparam int BW = COUNT_WIDTH + 4;
    localparam int SW = COUNT_WIDTH + 3;
    localparam logic [1:0] SEL_ZERO = 2'd0;
    localparam logic [1:0] SEL_ONE  = 2'd1;
    localparam logic [1:0] SEL_HDR  = 2'd2;
    localparam logic [1:0] SEL_DAT  = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_FETCH, S_HEADER, S_DATA, S_END, S_WAIT
    } state_t;

    state_t                 r_state;
    logic                   r_clk, r_ready, r_busy, r_underrun, r_phase;
    logic [CHANNELS-1:0]    r_data;
    logic [7:0]             r_pages_left;
    logic [COUNT_WIDTH-1:0] r_leds_left, r_cfg_led;
    logic [1:0]             r_rep_left, r_cfg_rep;
    logic [DIV_WIDTH-1:0]   r_cfg_div, r_div;
    logic [4:0]             r_cfg_bri;
    logic [BW-1:0]          r_bit_idx;
    logic                   r_tog_d1, r_tog_d2;

    logic                   w_start_edge, w_quiet, w_tick, w_load, w_last_bit;
    logic [1:0]             w_sel;
    logic [BW-1:0]          w_seg_last, w_end_bits;
    logic [2:0]             w_rep_mul;
    logic [COUNT_WIDTH+1:0] w_slots;
    logic [SW-1:0]          w_slots_rnd;
    logic [CHANNELS-1:0]    w_lane_bit;

    assign pixel_ready = r_ready;
    assign clock_out   = r_clk;
    assign data_out    = r_data;
    assign busy        = r_busy;
    assign underrun    = r_underrun;

    // Sample start_toggle twice; any level change between samples is one start edge
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tog_d1 <= start_toggle;
            r_tog_d2 <= start_toggle;
        end else begin
            r_tog_d1 <= start_toggle;
            r_tog_d2 <= r_tog_d1;
        end
    end
    assign w_start_edge = r_tog_d1 ^ r_tog_d2;

    // Divider runs only while a page is on the wire, one tick per divisor+1 clk
    assign w_quiet = (r_state == S_IDLE) || (r_state == S_WAIT);
    assign w_tick  = !w_quiet && (r_div == r_cfg_div);
    always_ff @(posedge clk) begin
        if (rst || w_quiet || w_tick)
            r_div <= '0;
        else
            r_div <= r_div + DIV_WIDTH'(1);
    end

    // End frame: 32 + 8*ceil(slots/16) ones, slots = led_count*(repeat+1)
    assign w_rep_mul   = {1'b0, r_cfg_rep} + 3'd1;
    assign w_slots     = {2'b00, r_cfg_led} * {{(COUNT_WIDTH-1){1'b0}}, w_rep_mul};
    assign w_slots_rnd = {1'b0, w_slots} + SW'(15);
    assign w_end_bits  = BW'({w_slots_rnd[SW-1:4], 3'b000}) + BW'(32);

    // Segment length and lane bit source for the current state
    always_comb begin
        w_seg_last = '0;
        w_sel      = SEL_ZERO;
        case (r_state)
            S_START:  w_seg_last = BW'(31);
            S_HEADER: begin w_seg_last = BW'(7);  w_sel = SEL_HDR; end
            S_DATA:   begin w_seg_last = BW'(23); w_sel = SEL_DAT; end
            S_END:    begin w_seg_last = w_end_bits - BW'(1); w_sel = SEL_ONE; end
            default:  ;
        endcase
    end
    assign w_last_bit = (r_bit_idx == w_seg_last);
    assign w_load     = (r_state == S_FETCH) && r_ready && pixel_valid;

    for (genvar c = 0; c < CHANNELS; c++) begin : g_lane
        apa102_lane #(.PW(PW)) u_lane (
            .clk    (clk),
            .rst    (rst),
            .i_load (w_load),
            .i_pix  (pixel_data[c*PW +: PW]),
            .i_bri  (r_cfg_bri),
            .i_sel  (w_sel),
            .i_idx  (r_bit_idx[4:0]),
            .o_bit  (w_lane_bit[c])
        );
    end

    // Frame sequencer. Phase 0 drops clock and presents data; phase 1 raises clock.
    // Segment changes happen on the rising half, so FETCH starts with clock high. It
    // then drops clock and presents the first header bit, which is always 1, and
    // stays paused low until a pixel arrives.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_clk        <= 1'b0;
            r_data       <= '0;
            r_ready      <= 1'b0;
            r_busy       <= 1'b0;
            r_underrun   <= 1'b0;
            r_phase      <= 1'b0;
            r_pages_left <= '0;
            r_leds_left  <= '0;
            r_rep_left   <= '0;
            r_bit_idx    <= '0;
            r_cfg_led    <= '0;
            r_cfg_rep    <= '0;
            r_cfg_div    <= '0;
            r_cfg_bri    <= '0;
        end else begin
            case (r_state)
                S_IDLE, S_WAIT: begin
                    r_clk <= 1'b0;
                    if (w_start_edge) begin
                        r_cfg_led  <= led_count;
                        r_cfg_rep  <= repeat_count;
                        r_cfg_div  <= clock_divisor;
                        r_cfg_bri  <= global_brightness;
                        r_busy     <= 1'b1;
                        r_underrun <= 1'b0;
                        r_bit_idx  <= '0;
                        r_phase    <= 1'b0;
                        r_state    <= S_START;
                        if (r_state == S_IDLE)
                            r_pages_left <= (page_count == 8'd0) ? 8'd1 : page_count;
                    end
                end
                S_FETCH: begin
                    if (!pixel_valid)
                        r_underrun <= 1'b1;
                    if (w_tick && !r_phase) begin
                        r_clk   <= 1'b0;
                        r_data  <= '1;
                        r_phase <= 1'b1;
                    end
                    if (w_load) begin
                        r_ready    <= 1'b0;
                        r_rep_left <= r_cfg_rep;
                        r_bit_idx  <= '0;
                        r_state    <= S_HEADER;
                    end
                end
                default: begin
                    if (w_tick) begin
                        if (!r_phase) begin
                            r_clk   <= 1'b0;
                            r_data  <= w_lane_bit;
                            r_phase <= 1'b1;
                        end else begin
                            r_clk   <= 1'b1;
                            r_phase <= 1'b0;
                            if (!w_last_bit) begin
                                r_bit_idx <= r_bit_idx + BW'(1);
                            end else begin
                                r_bit_idx <= '0;
                                case (r_state)
                                    S_START: begin
                                        if (r_cfg_led == '0) begin
                                            r_state <= S_END;
                                        end else begin
                                            r_leds_left <= r_cfg_led;
                                            r_ready     <= 1'b1;
                                            r_state     <= S_FETCH;
                                        end
                                    end
                                    S_HEADER: r_state <= S_DATA;
                                    S_DATA: begin
                                        if (r_rep_left != 2'd0) begin
                                            r_rep_left <= r_rep_left - 2'd1;
                                            r_state    <= S_HEADER;
                                        end else if (r_leds_left > COUNT_WIDTH'(1)) begin
                                            r_leds_left <= r_leds_left - COUNT_WIDTH'(1);
                                            r_ready     <= 1'b1;
                                            r_state     <= S_FETCH;
                                        end else begin
                                            r_leds_left <= '0;
                                            r_state     <= S_END;
                                        end
                                    end
                                    S_END: begin
                                        r_busy <= 1'b0;
                                        if (r_pages_left > 8'd1) begin
                                            r_pages_left <= r_pages_left - 8'd1;
                                            r_state      <= S_WAIT;
                                        end else begin
                                            r_pages_left <= '0;
                                            r_state      <= S_IDLE;
                                        end
                                    end
                                    default: r_state <= S_IDLE;
                                endcase
                            end
                        end
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_apa102_multi_out.sv
// Directed bench for apa102_multi_out. A monitor records data_out at every rising
// edge of clock_out. Expected frames are built from hand-written frame structure
// and the pixel table.
module tb_apa102_multi_out;
    localparam int CH = 4;
    localparam int PW = 24;

    logic              clk = 1'b0;
    logic              rst;
    logic              start_toggle;
    logic [15:0]       led_count;
    logic [1:0]        repeat_count;
    logic [7:0]        page_count;
    logic [7:0]        clock_divisor;
    logic [4:0]        global_brightness;
    logic [CH*PW-1:0]  pixel_data;
    logic              pixel_valid;
    logic              pixel_ready, clock_out, busy, underrun;
    logic [CH-1:0]     data_out;

    int n_asserts = 0;
    int n_fails   = 0;
    int cyc       = 0;
    int hs_cnt    = 0;
    int ready_cnt = 0;
    bit hs_pend   = 1'b0;
    bit mon_prev  = 1'b0;
    logic [CH-1:0] cap[$];
    int            cap_cyc[$];
    logic [CH-1:0] exp_q[$];
    int frame_base, hs0, rdy0, n0, guard;

    apa102_multi_out #(.CHANNELS(CH), .COUNT_WIDTH(16), .DIV_WIDTH(8)) dut (
        .clk(clk), .rst(rst), .start_toggle(start_toggle), .led_count(led_count),
        .repeat_count(repeat_count), .page_count(page_count), .clock_divisor(clock_divisor),
        .global_brightness(global_brightness), .pixel_data(pixel_data),
        .pixel_valid(pixel_valid), .pixel_ready(pixel_ready), .clock_out(clock_out),
        .data_out(data_out), .busy(busy), .underrun(underrun)
    );

    always #5 clk = ~clk;

    function automatic logic [23:0] pix(input int c, input int k);
        logic [7:0] b, g, r;
        b = 8'(k * 16 + c + 1);
        g = 8'(8'hC3 ^ k);
        r = 8'(8'h5A + 3 * c);
        return {b, g, r};
    endfunction

    always_comb begin
        pixel_data = '0;
        for (int c = 0; c < CH; c++) pixel_data[c*PW +: PW] = pix(c, hs_cnt);
    end

    always @(posedge clk) cyc++;

    // Capture each bit on the rising edge of clock_out; count handshakes and ready cycles
    always @(negedge clk) begin
        if (clock_out && !mon_prev) begin
            cap.push_back(data_out);
            cap_cyc.push_back(cyc);
        end
        mon_prev = clock_out;
        if (hs_pend) hs_cnt++;
        hs_pend = pixel_ready && pixel_valid && !rst;
        if (pixel_ready) ready_cnt++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] expv);
        n_asserts++;
        assert (got === expv) else begin
            n_fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, expv);
        end
    endtask

    task automatic exp_fill(input logic [CH-1:0] v, input int n);
        repeat (n) exp_q.push_back(v);
    endtask

    task automatic exp_led(input int k, input logic [4:0] bri, input int copies);
        logic [7:0]    h;
        logic [23:0]   p;
        logic [CH-1:0] v;
        h = {3'b111, bri};
        for (int r = 0; r < copies; r++) begin
            for (int i = 7; i >= 0; i--) exp_q.push_back({CH{h[i]}});
            for (int i = 23; i >= 0; i--) begin
                for (int c = 0; c < CH; c++) begin
                    p = pix(c, k);
                    v[c] = p[i];
                end
                exp_q.push_back(v);
            end
        end
    endtask

    task automatic check_frame(input string tag);
        int n, errs;
        n = cap.size() - frame_base;
        check({tag, " bit count"}, n, exp_q.size());
        for (int c = 0; c < CH; c++) begin
            errs = 0;
            for (int i = 0; i < exp_q.size() && i < n; i++)
                if (cap[frame_base + i][c] !== exp_q[i][c]) errs++;
            check($sformatf("%s lane%0d bit errors", tag, c), errs, 0);
        end
        exp_q.delete();
    endtask

    task automatic wait_done(input string tag);
        guard = 0;
        while (busy && guard < 20000) begin
            tick();
            guard++;
        end
        check({tag, " frame done"}, busy, 0);
        tick();
    endtask

    task automatic run_frame(input string tag, input bit extra);
        frame_base = cap.size();
        start_toggle = ~start_toggle;
        tick();
        check({tag, " busy before latch"}, busy, 0);
        tick();
        check({tag, " busy after start"}, busy, 1);
        if (extra) begin
            repeat (10) tick();
            start_toggle = ~start_toggle;
        end
        wait_done(tag);
        check_frame(tag);
    endtask

    initial begin
        rst = 1'b1; start_toggle = 1'b0; led_count = 16'd2; repeat_count = 2'd0;
        page_count = 8'd0; clock_divisor = 8'd0; global_brightness = 5'h1F; pixel_valid = 1'b1;
        repeat (3) tick();
        check("reset clock_out", clock_out, 0);
        check("reset data_out", data_out, 0);
        check("reset pixel_ready", pixel_ready, 0);
        check("reset busy", busy, 0);
        check("reset underrun", underrun, 0);
        rst = 1'b0;
        repeat (3) tick();
        check("no start from reset", busy, 0);

        // Basic frame: 2 LEDs, no repeat, fastest clock
        hs0 = hs_cnt;
        exp_fill('0, 32); exp_led(hs0, 5'h1F, 1); exp_led(hs0 + 1, 5'h1F, 1); exp_fill('1, 40);
        run_frame("basic", 1'b0);
        check("basic handshakes", hs_cnt - hs0, 2);
        check("basic clock period", cap_cyc[frame_base + 1] - cap_cyc[frame_base], 2);
        check("basic period at fetch", cap_cyc[frame_base + 32] - cap_cyc[frame_base + 31], 2);

        // Repeat x3 from one handshake, divided clock, other brightness
        led_count = 16'd1; repeat_count = 2'd2; clock_divisor = 8'd2; global_brightness = 5'h0A;
        hs0 = hs_cnt;
        exp_fill('0, 32); exp_led(hs0, 5'h0A, 3); exp_fill('1, 40);
        run_frame("repeat", 1'b0);
        check("repeat handshakes", hs_cnt - hs0, 1);
        check("repeat clock period", cap_cyc[frame_base + 5] - cap_cyc[frame_base + 4], 6);

        // Underrun: hold pixel_valid low for 50 clk in FETCH
        repeat_count = 2'd0; clock_divisor = 8'd0; global_brightness = 5'h13; pixel_valid = 1'b0;
        hs0 = hs_cnt;
        exp_fill('0, 32); exp_led(hs0, 5'h13, 1); exp_fill('1, 40);
        frame_base = cap.size();
        start_toggle = ~start_toggle;
        guard = 0;
        while (!pixel_ready && guard < 1000) begin
            tick();
            guard++;
        end
        check("stall ready seen", pixel_ready, 1);
        tick(); tick();
        n0 = cap.size();
        repeat (48) tick();
        check("stall clock low", clock_out, 0);
        check("stall no clock edges", cap.size() - n0, 0);
        check("stall underrun set", underrun, 1);
        pixel_valid = 1'b1;
        wait_done("stall");
        check_frame("stall");
        check("underrun sticky", underrun, 1);

        // Zero LEDs: only start and end frames, no ready
        led_count = 16'd0;
        rdy0 = ready_cnt;
        exp_fill('0, 32); exp_fill('1, 32);
        run_frame("zero", 1'b0);
        check("zero ready never", ready_cnt - rdy0, 0);
        check("underrun cleared by start", underrun, 0);

        // Three pages, a fourth edge while busy is dropped
        led_count = 16'd1; page_count = 8'd3; global_brightness = 5'h1F;
        exp_fill('0, 32); exp_led(hs_cnt, 5'h1F, 1); exp_fill('1, 40);
        run_frame("page1", 1'b0);
        exp_fill('0, 32); exp_led(hs_cnt, 5'h1F, 1); exp_fill('1, 40);
        run_frame("page2", 1'b0);
        exp_fill('0, 32); exp_led(hs_cnt, 5'h1F, 1); exp_fill('1, 40);
        run_frame("page3", 1'b1);
        n0 = cap.size();
        repeat (100) tick();
        check("extra edge ignored busy", busy, 0);
        check("extra edge ignored bits", cap.size() - n0, 0);

        // Reset in the middle of DATA, then a clean frame
        led_count = 16'd2; page_count = 8'd1;
        frame_base = cap.size();
        start_toggle = ~start_toggle;
        guard = 0;
        while (cap.size() - frame_base < 45 && guard < 2000) begin
            tick();
            guard++;
        end
        check("reached mid data", cap.size() - frame_base >= 45, 1);
        rst = 1'b1;
        tick();
        check("rst clock_out", clock_out, 0);
        check("rst data_out", data_out, 0);
        check("rst busy", busy, 0);
        check("rst pixel_ready", pixel_ready, 0);
        rst = 1'b0;
        repeat (5) tick();
        check("rst stays idle", busy, 0);
        hs0 = hs_cnt;
        exp_fill('0, 32); exp_led(hs0, 5'h1F, 1); exp_led(hs0 + 1, 5'h1F, 1); exp_fill('1, 40);
        run_frame("after rst", 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
        $finish;
    end
endmodule
